// File: rtl/modbus_poll_scheduler.sv
// Master-side Modbus RTU poll sequencer: reads the slave's holding-register window
// block by block (function 0x03) and commits each register of a good response to the demux.
module modbus_poll_scheduler #(
    parameter logic [7:0] SLAVE_ID    = 8'd1,
    parameter int         BASE_ADDR   = 340,
    parameter int         NUM_REGS    = 30,
    parameter int         BLOCK_SIZE  = 10,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         MAX_RETRY   = 3,
    parameter int         GAP_CYC     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    // tx_req/tx_ack: tx_req rises with the address fields already stable and holds
    // them unchanged until the single-cycle tx_ack; tx_req falls on the next cycle.
    output logic        tx_req,
    input  logic        tx_ack,
    output logic [7:0]  tx_slave,
    output logic [7:0]  tx_func,
    output logic [15:0] tx_start_addr,
    output logic [7:0]  tx_count,
    input  logic        rx_done,
    input  logic        rx_crc_ok,
    input  logic [7:0]  rx_adr,
    input  logic [7:0]  rx_nregs,
    output logic        commit_strb,
    output logic [7:0]  commit_n,
    output logic        busy,
    output logic        link_ok,
    output logic [15:0] err_cnt,
    output logic        cycle_done,
    output logic [2:0]  dbg_state
);

    localparam int NUM_BLOCKS = (NUM_REGS + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t        state;
    logic [BW-1:0] block;
    logic [RW-1:0] retry;
    logic [TW-1:0] timer;
    logic [GW-1:0] gap_cnt;

    logic [15:0]   offset;
    logic [15:0]   remain;
    logic [15:0]   blk_count;
    logic [15:0]   req_addr;
    logic [7:0]    req_count;
    logic [7:0]    first_n;
    logic [7:0]    last_n;
    logic          last_block;
    logic [BW-1:0] next_block;
    logic          rsp_good;
    logic          timed_out;
    logic          retry_last;
    logic          gap_done;

    // Geometry of the current block; the last block may be shorter than BLOCK_SIZE.
    assign offset     = 16'(block) * 16'(BLOCK_SIZE);
    assign remain     = 16'(NUM_REGS) - offset;
    assign blk_count  = (remain < 16'(BLOCK_SIZE)) ? remain : 16'(BLOCK_SIZE);
    assign req_addr   = 16'(BASE_ADDR) + offset;
    assign req_count  = 8'(blk_count);
    assign first_n    = 8'(offset + 16'd1);
    assign last_n     = 8'(offset + blk_count);
    assign last_block = (block == BW'(NUM_BLOCKS - 1));
    assign next_block = last_block ? '0 : block + BW'(1);

    assign rsp_good   = rx_crc_ok && (rx_adr == SLAVE_ID) && (rx_nregs == tx_count);
    assign timed_out  = (timer == TW'(TIMEOUT_CYC - 1));
    assign retry_last = (retry == RW'(MAX_RETRY - 1));
    assign gap_done   = (gap_cnt == GW'(GAP_CYC - 1));

    assign tx_slave  = SLAVE_ID;
    assign tx_func   = 8'h03;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            block         <= '0;
            retry         <= '0;
            timer         <= '0;
            gap_cnt       <= '0;
            tx_req        <= 1'b0;
            tx_start_addr <= '0;
            tx_count      <= '0;
            commit_strb   <= 1'b0;
            commit_n      <= '0;
            busy          <= 1'b0;
            link_ok       <= 1'b0;
            err_cnt       <= '0;
            cycle_done    <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state         <= S_REQ;
                        busy          <= 1'b1;
                        tx_req        <= 1'b1;
                        tx_start_addr <= req_addr;
                        tx_count      <= req_count;
                    end
                end

                S_REQ: begin
                    if (tx_ack) begin
                        tx_req <= 1'b0;
                        timer  <= '0;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (rx_done && rsp_good) begin
                        state       <= S_COMMIT;
                        link_ok     <= 1'b1;
                        retry       <= '0;
                        commit_strb <= 1'b1;
                        commit_n    <= first_n;
                    end else if (rx_done || timed_out) begin
                        // A bad frame wins over a coincident timeout; both cost one attempt.
                        gap_cnt <= '0;
                        state   <= S_GAP;
                        if (retry_last) begin
                            retry      <= '0;
                            link_ok    <= 1'b0;
                            block      <= next_block;
                            cycle_done <= last_block;
                            if (err_cnt != 16'hFFFF) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end else begin
                            retry <= retry + RW'(1);
                        end
                    end
                end

                S_COMMIT: begin
                    if (commit_n == last_n) begin
                        commit_strb <= 1'b0;
                        block       <= next_block;
                        cycle_done  <= last_block;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        commit_n <= commit_n + 8'd1;
                    end
                end

                S_GAP: begin
                    if (gap_done) begin
                        if (enable) begin
                            state         <= S_REQ;
                            tx_req        <= 1'b1;
                            tx_start_addr <= req_addr;
                            tx_count      <= req_count;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/modbus_poll_scheduler.md
Name: modbus_poll_scheduler

Overview:
- Master-side poll sequencer for a single Modbus RTU slave.
- Splits the slave's holding-register window into blocks and issues one read request (function 0x03) per block through the frame transmitter.
- Waits for the receiver's verdict, with timeout and retry.
- On a good response, steps the register-bank demux through every received index with one commit strobe per register, so outputs update only from CRC-checked frames.

Parameters:
SLAVE_ID, 1, Modbus address polled and expected in responses
BASE_ADDR, 340, register address of bank index 1
NUM_REGS, 30, total registers in the window (bank indices 1..NUM_REGS)
BLOCK_SIZE, 10, maximum registers per request
TIMEOUT_CYC, 50000, clk cycles to wait for rx_done after tx_ack
MAX_RETRY, 3, attempts per block before it is declared failed
GAP_CYC, 1000, idle clk cycles between transactions

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  polling permitted
tx_req  out  1  request to frame transmitter; held until tx_ack
tx_ack  in  1  one-cycle accept from transmitter
tx_slave  out  8  slave address (=SLAVE_ID)
tx_func  out  8  function code, constant 8'h03
tx_start_addr  out  16  first register address of block
tx_count  out  8  registers requested
rx_done  in  1  one-cycle pulse: response frame finished
rx_crc_ok  in  1  CRC verdict, valid with rx_done
rx_adr  in  8  slave address in response, valid with rx_done
rx_nregs  in  8  registers in response, valid with rx_done
commit_strb  out  1  crc_validate to demux; one pulse per register
commit_n  out  8  bank index (n_data) for demux, valid with commit_strb
busy  out  1  high in any state other than IDLE
link_ok  out  1  last completed block succeeded
err_cnt  out  16  failed blocks, saturating
cycle_done  out  1  one-cycle pulse after the last block of a sweep

Behaviour:
- Reset (sync, overrides all): state IDLE, block=0, retry=0, all counters 0. Outputs: tx_req=0, tx_start_addr=0, tx_count=0, commit_strb=0, commit_n=0, busy=0, link_ok=0, err_cnt=0, cycle_done=0. tx_slave and tx_func are constants. Reset mid-transaction drops tx_req the same cycle; no commit is issued.
- Block geometry: offset=block*BLOCK_SIZE; count=min(BLOCK_SIZE, NUM_REGS-offset); tx_start_addr=BASE_ADDR+offset; tx_count=count. Last block may be partial (e.g. NUM_REGS=25 -> 10,10,5).
- IDLE: if enable=1 -> REQ on next edge.
- REQ: tx_req=1, address fields stable. On tx_ack: tx_req=0 the next cycle, timer cleared -> WAIT.
- WAIT: timer increments each cycle.
  - Good response: rx_done & rx_crc_ok & rx_adr==SLAVE_ID & rx_nregs==tx_count -> COMMIT, link_ok=1, retry=0.
  - Bad response (rx_done with any other combination) or timer==TIMEOUT_CYC-1: counts as an attempt failure.
  - rx_done takes priority over a timeout in the same cycle.
- Attempt failure: retry+1. If retry+1 < MAX_RETRY -> GAP, then the same block is re-requested. Otherwise: block failed, err_cnt+1 (saturates at 16'hFFFF), link_ok=0, retry=0, advance block -> GAP.
- COMMIT: count consecutive cycles, commit_strb=1 with commit_n=offset+1 .. offset+count, one index per cycle. Advance block, then -> GAP.
- Block advance: block+1; wrap to 0 after the last block. The wrap cycle pulses cycle_done=1 for one cycle, on the transition into GAP.
- GAP: wait GAP_CYC cycles. Then, if enable=1 -> REQ; else -> IDLE.
- enable is ignored mid-transaction; it is sampled only at GAP exit and in IDLE.
- rx_done outside WAIT is ignored.
- Latency: good rx_done at cycle T gives the first commit_strb at T+1 and the last at T+count.

Test Plan:
- Reset then enable=1, tx_ack after 3 cycles: tx_req stays high 3 cycles; tx_start_addr=340, tx_count=10; busy=1.
- Good response for block 0 -> commit_n 1..10 on 10 consecutive strobed cycles; link_ok=1; next request (after GAP_CYC) has start 350.
- Three good blocks -> third request start 360, count 10; cycle_done pulses once; the fourth request returns to 340.
- No rx_done (TIMEOUT_CYC=100) -> block 0 requested 3 times; err_cnt=1; link_ok=0; next request is start 350; no commit_strb.
- rx_done with rx_crc_ok=0, then good response -> one retry of the same block (start 340); commit 1..10; err_cnt unchanged.
- rx_adr=2 or rx_nregs=9 -> treated as failure, no commit. Separately: reset asserted in COMMIT at commit_n=4 -> strobes stop the next cycle; all outputs take their reset values.
